// File: rtl/nn_ctrl_pkg.sv
// Shared types and helpers for the layered NN phase sequencer.
package nn_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, FWD, BWD, DONE} seq_state_t;
  typedef enum logic       {MODE_TRAIN, MODE_VAL} seq_mode_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nn_phase_timer.sv
// Phase counter: clears to zero on request, otherwise counts up; flags when it equals the terminal value.
module nn_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/nn_phase_sequencer.sv
// Training/validation sequencer: per-layer forward windows, overlapped backward windows,
// one-deep pending request slot, abort with acknowledge. All outputs registered.
module nn_phase_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int FWD_CYCLES = 4,
  parameter int BWD_CYCLES = 10,
  parameter int BWD_LAG    = 2,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_train,
  input  logic                  start_val,
  input  logic                  abort,
  output logic [NUM_LAYERS-1:0] fwd_en,
  output logic [NUM_LAYERS-1:0] fwd_start,
  output logic [NUM_LAYERS-1:0] bwd_en,
  output logic [NUM_LAYERS-1:0] bwd_start,
  output logic                  train_done,
  output logic                  val_done,
  output logic                  abort_ack,
  output logic                  req_drop,
  output logic                  busy
);

  localparam int FWD_LEN = NUM_LAYERS * FWD_CYCLES;
  localparam int BWD_LEN = (NUM_LAYERS - 1) * BWD_LAG + BWD_CYCLES;
  localparam logic [CNT_W-1:0] FWD_TERM = CNT_W'(FWD_LEN - 1);
  localparam logic [CNT_W-1:0] BWD_TERM = CNT_W'(BWD_LEN - 1);

  // The counter never wraps, so the longest phase must fit in CNT_W bits.
  if (max_int(FWD_LEN, BWD_LEN) > (1 << CNT_W)) begin : g_cnt_w_check
    $error("nn_phase_sequencer: CNT_W too small for phase length");
  end

  seq_state_t state_q, state_d;
  seq_mode_t  mode_q, mode_d, pend_mode_q, pend_mode_d, req_mode;
  logic       pend_vld_q, pend_vld_d;
  logic       any_start, both_start, drop_d;

  logic [CNT_W-1:0] t_cnt, term;
  logic [31:0]      t_w;
  logic             tc, tmr_clr;

  logic [NUM_LAYERS-1:0] fwd_en_d, fwd_start_d, bwd_en_d, bwd_start_d;
  logic [NUM_LAYERS-1:0] fwd_en_q, fwd_start_q, bwd_en_q, bwd_start_q;
  logic train_done_d, val_done_d;
  logic train_done_q, val_done_q, abort_ack_q, req_drop_q;

  assign term    = (state_q == FWD) ? FWD_TERM : BWD_TERM;
  assign tmr_clr = abort | tc | (state_q == IDLE) | (state_q == DONE);
  assign t_w     = 32'(t_cnt);

  nn_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tmr_clr),
    .term_i (term),
    .cnt_o  (t_cnt),
    .tc_o   (tc)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pend_vld_d  = pend_vld_q;
    pend_mode_d = pend_mode_q;
    drop_d      = 1'b0;
    any_start   = start_train | start_val;
    both_start  = start_train & start_val;
    req_mode    = start_train ? MODE_TRAIN : MODE_VAL;
    if (abort) begin
      state_d    = IDLE;
      pend_vld_d = 1'b0;
    end else begin
      // Requests arriving mid-pass go to the single pending slot; overflow is dropped.
      if ((state_q == FWD || state_q == BWD) && any_start) begin
        if (!pend_vld_q) begin
          pend_vld_d  = 1'b1;
          pend_mode_d = req_mode;
          drop_d      = both_start;
        end else begin
          drop_d = 1'b1;
        end
      end
      unique case (state_q)
        IDLE: if (any_start) begin
          state_d = FWD;
          mode_d  = req_mode;
          drop_d  = both_start;
        end
        FWD: if (tc) state_d = (mode_q == MODE_TRAIN) ? BWD : DONE;
        BWD: if (tc) state_d = DONE;
        DONE: begin
          if (pend_vld_q) begin
            state_d    = FWD;
            mode_d     = pend_mode_q;
            pend_vld_d = 1'b0;
            drop_d     = any_start;
          end else if (any_start) begin
            state_d = FWD;
            mode_d  = req_mode;
            drop_d  = both_start;
          end else begin
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
    localparam int unsigned F_LO = l * FWD_CYCLES;
    localparam int unsigned B_LO = (NUM_LAYERS - 1 - l) * BWD_LAG;
    // Unsigned difference wraps for t below the window start, so one compare covers both bounds.
    assign fwd_en_d[l]    = !abort && (state_q == FWD) && ((t_w - F_LO) < FWD_CYCLES);
    assign fwd_start_d[l] = !abort && (state_q == FWD) && (t_w == F_LO);
    assign bwd_en_d[l]    = !abort && (state_q == BWD) && ((t_w - B_LO) < BWD_CYCLES);
    assign bwd_start_d[l] = !abort && (state_q == BWD) && (t_w == B_LO);
  end

  assign train_done_d = !abort && (state_q == DONE) && (mode_q == MODE_TRAIN);
  assign val_done_d   = !abort && (state_q == DONE) && (mode_q == MODE_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= MODE_TRAIN;
      pend_vld_q   <= 1'b0;
      pend_mode_q  <= MODE_TRAIN;
      fwd_en_q     <= '0;
      fwd_start_q  <= '0;
      bwd_en_q     <= '0;
      bwd_start_q  <= '0;
      train_done_q <= 1'b0;
      val_done_q   <= 1'b0;
      abort_ack_q  <= 1'b0;
      req_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      pend_vld_q   <= pend_vld_d;
      pend_mode_q  <= pend_mode_d;
      fwd_en_q     <= fwd_en_d;
      fwd_start_q  <= fwd_start_d;
      bwd_en_q     <= bwd_en_d;
      bwd_start_q  <= bwd_start_d;
      train_done_q <= train_done_d;
      val_done_q   <= val_done_d;
      abort_ack_q  <= abort;
      req_drop_q   <= drop_d;
    end
  end

  assign fwd_en     = fwd_en_q;
  assign fwd_start  = fwd_start_q;
  assign bwd_en     = bwd_en_q;
  assign bwd_start  = bwd_start_q;
  assign train_done = train_done_q;
  assign val_done   = val_done_q;
  assign abort_ack  = abort_ack_q;
  assign req_drop   = req_drop_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_nn_phase_sequencer.sv
// Directed bench: table of per-cycle vectors for the 2-layer default, plus hand sequences
// for pending/abort corners and a 4-layer instance for staggered backward starts and async reset.
module tb_nn_phase_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_train, start_val, abort;
  logic [1:0] fwd_en, fwd_start, bwd_en, bwd_start;
  logic train_done, val_done, abort_ack, req_drop, busy;

  logic rst_n4, start_train4, start_val4, abort4;
  logic [3:0] fwd_en4, fwd_start4, bwd_en4, bwd_start4;
  logic train_done4, val_done4, abort_ack4, req_drop4, busy4;

  nn_phase_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start_train(start_train), .start_val(start_val), .abort(abort),
    .fwd_en(fwd_en), .fwd_start(fwd_start), .bwd_en(bwd_en), .bwd_start(bwd_start),
    .train_done(train_done), .val_done(val_done), .abort_ack(abort_ack), .req_drop(req_drop),
    .busy(busy)
  );

  nn_phase_sequencer #(.NUM_LAYERS(4), .FWD_CYCLES(2), .BWD_CYCLES(4), .BWD_LAG(3), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n4), .start_train(start_train4), .start_val(start_val4), .abort(abort4),
    .fwd_en(fwd_en4), .fwd_start(fwd_start4), .bwd_en(bwd_en4), .bwd_start(bwd_start4),
    .train_done(train_done4), .val_done(val_done4), .abort_ack(abort_ack4), .req_drop(req_drop4),
    .busy(busy4)
  );

  typedef struct {
    logic       st, sv, ab;
    logic [1:0] fe, fs, be, bs;
    logic [4:0] fl; // {train_done, val_done, abort_ack, req_drop, busy}
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [12:0] obs();
    return {fwd_en, fwd_start, bwd_en, bwd_start, train_done, val_done, abort_ack, req_drop, busy};
  endfunction

  function automatic logic [20:0] obs4();
    return {fwd_en4, fwd_start4, bwd_en4, bwd_start4, train_done4, val_done4, abort_ack4, req_drop4, busy4};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic sv, input logic ab);
    start_train = st; start_val = sv; abort = ab;
    @(posedge clk); #1;
    start_train = 1'b0; start_val = 1'b0; abort = 1'b0;
  endtask

  task automatic cyc4(input logic st);
    start_train4 = st;
    @(posedge clk); #1;
    start_train4 = 1'b0;
  endtask

  task automatic add(input int n, input logic st, input logic sv, input logic ab,
                     input logic [1:0] fe, input logic [1:0] fs, input logic [1:0] be,
                     input logic [1:0] bs, input logic [4:0] fl);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.st = st; v.sv = sv; v.ab = ab;
      v.fe = fe; v.fs = fs; v.be = be; v.bs = bs; v.fl = fl;
      tbl.push_back(v);
    end
  endtask

  task automatic add_fwd();
    add(1, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 5'b00001);
    add(3, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 5'b00001);
    add(1, 0, 0, 0, 2'b10, 2'b10, 2'b00, 2'b00, 5'b00001);
    add(3, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 5'b00001);
  endtask

  task automatic add_train(input logic both);
    add(1, 1, both, 0, 2'b00, 2'b00, 2'b00, 2'b00, both ? 5'b00011 : 5'b00001);
    add_fwd();
    add(1, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b10, 5'b00001);
    add(1, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b00, 5'b00001);
    add(1, 0, 0, 0, 2'b00, 2'b00, 2'b11, 2'b01, 5'b00001);
    add(7, 0, 0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 5'b00001);
    add(2, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 5'b00001);
    add(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 5'b10000);
    add(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00000);
  endtask

  task automatic add_val();
    add(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00001);
    add_fwd();
    add(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 5'b01000);
    add(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 5'b00000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] acc;
    logic [3:0]  exp_bs;
    rst_n = 1'b0; rst_n4 = 1'b0;
    start_train = 1'b0; start_val = 1'b0; abort = 1'b0;
    start_train4 = 1'b0; start_val4 = 1'b0; abort4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(obs()), 32'd0);
    chk("reset_outputs4", 32'(obs4()), 32'd0);
    rst_n = 1'b1; rst_n4 = 1'b1;
    cyc(0, 0, 0);
    chk("idle_after_reset", 32'(obs()), 32'd0);

    add_train(1'b0);
    add_val();
    add_train(1'b1);
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].st, tbl[i].sv, tbl[i].ab);
      chk($sformatf("row%0d", i), 32'(obs()),
          32'({tbl[i].fe, tbl[i].fs, tbl[i].be, tbl[i].bs, tbl[i].fl}));
    end

    // Pending: val stored during BWD, second start dropped, val launches right after train_done.
    cyc(1, 0, 0);
    repeat (12) cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("pend_store_no_drop", 32'(req_drop), 32'd0);
    cyc(1, 0, 0);
    chk("pend_full_drop", 32'(req_drop), 32'd1);
    repeat (7) cyc(0, 0, 0);
    chk("pend_train_done", 32'(obs()), 32'(13'b00000000_10001));
    acc = '0;
    cyc(0, 0, 0);
    chk("pend_val_fwd_start", 32'({fwd_start, busy}), 32'(3'b011));
    acc = acc | 13'(bwd_en);
    repeat (7) begin
      cyc(0, 0, 0);
      acc = acc | 13'(bwd_en);
    end
    cyc(0, 0, 0);
    chk("pend_val_done", 32'(obs()), 32'(13'b00000000_01000));
    chk("pend_val_no_bwd", 32'(acc), 32'd0);

    // Abort at BWD t=3 with a request pending.
    cyc(1, 0, 0);
    repeat (8) cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("abort_pre_bwd_en", 32'(bwd_en), 32'(2'b11));
    cyc(0, 0, 1);
    chk("abort_ack_cycle", 32'(obs()), 32'(13'b00000000_00100));
    acc = '0;
    repeat (30) begin
      cyc(0, 0, 0);
      acc = acc | obs();
    end
    chk("abort_quiet", 32'(acc), 32'd0);

    // Abort in IDLE beats simultaneous starts.
    cyc(1, 1, 1);
    chk("abort_idle_ack", 32'(obs()), 32'(13'b00000000_00100));
    cyc(0, 0, 0);
    chk("abort_idle_after", 32'(obs()), 32'd0);

    // Four layers: staggered backward starts at t=0,3,6,9.
    cyc4(1'b1);
    cyc4(1'b0);
    chk("l4_fwd_start0", 32'(fwd_start4), 32'(4'b0001));
    repeat (7) cyc4(1'b0);
    chk("l4_fwd_en3", 32'(fwd_en4), 32'(4'b1000));
    for (int r = 9; r <= 21; r++) begin
      cyc4(1'b0);
      case (r)
        9:       exp_bs = 4'b1000;
        12:      exp_bs = 4'b0100;
        15:      exp_bs = 4'b0010;
        18:      exp_bs = 4'b0001;
        default: exp_bs = 4'b0000;
      endcase
      chk($sformatf("l4_bwd_start_r%0d", r), 32'(bwd_start4), 32'(exp_bs));
      if (r == 12) chk("l4_bwd_en_t3", 32'(bwd_en4), 32'(4'b1100));
      if (r == 15) chk("l4_bwd_en_t6", 32'(bwd_en4), 32'(4'b0110));
    end
    cyc4(1'b0);
    chk("l4_train_done", 32'({train_done4, bwd_en4}), 32'(5'b10000));

    // Async reset in the middle of FWD.
    cyc4(1'b1);
    repeat (3) cyc4(1'b0);
    chk("l4_mid_fwd", 32'(fwd_en4), 32'(4'b0010));
    #2 rst_n4 = 1'b0;
    #1;
    chk("l4_async_reset", 32'(obs4()), 32'd0);
    #2 rst_n4 = 1'b1;
    cyc4(1'b0);
    chk("l4_after_reset", 32'(obs4()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
